// File: rtl/cpu_sequencer.sv
// Program sequencer for the CPU datapath: steps through 18-bit commands held in a
// small program RAM and bridges the in/out word streams for OutToRam / RamToOut.
module cpu_sequencer #(
    parameter int         PROG_DEPTH = 64,
    parameter logic [2:0] NOP_OP     = 3'b110,
    parameter logic [2:0] HALT_OP    = 3'b111,
    localparam int        AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [15:0]   retired,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data [0:15],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data [0:15],
    output logic [2:0]    op,
    output logic [8:0]    ram_addr,
    output logic [3:0]    ram_cnt,
    output logic [1:0]    reg_sel,
    output logic [31:0]   ram_input [0:15],
    input  logic [31:0]   ram_output [0:15]
);

    localparam logic [2:0] OP_RAM_TO_OUT = 3'b100;
    localparam logic [2:0] OP_OUT_TO_RAM = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_CAPT,
        S_WOUT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [15:0]   r_retired;
    logic [15:0]   w_retired_next;
    logic [17:0]   r_instr;
    logic [17:0]   r_prog_mem [0:PROG_DEPTH-1];
    logic [2:0]    r_op;
    logic [2:0]    w_op_next;
    logic [8:0]    r_ram_addr;
    logic [3:0]    r_ram_cnt;
    logic [1:0]    r_reg_sel;
    logic [31:0]   r_ram_input [0:15];
    logic [31:0]   r_out_data [0:15];
    logic          r_out_valid;
    logic          w_out_valid_next;
    logic          w_issue;
    logic          w_load_in;
    logic          w_capture;
    logic          w_advance;
    logic          w_in_ready;
    logic [2:0]    w_instr_op;

    assign w_instr_op = r_instr[17:15];

    // Program RAM: writes only while idle, registered read feeds the instruction register.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && (r_state == S_IDLE)) begin
            r_prog_mem[prog_addr] <= prog_data;
        end
        if (r_state == S_FETCH) begin
            r_instr <= r_prog_mem[r_pc];
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_retired_next   = r_retired;
        w_op_next        = NOP_OP;
        w_out_valid_next = r_out_valid;
        w_issue          = 1'b0;
        w_load_in        = 1'b0;
        w_capture        = 1'b0;
        w_advance        = 1'b0;
        w_in_ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_FETCH;
                    w_pc_next      = '0;
                    w_retired_next = '0;
                end
            end
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_instr_op == HALT_OP) begin
                    w_state_next = S_DONE;
                end else if (w_instr_op == OP_OUT_TO_RAM) begin
                    if (in_valid) begin
                        w_in_ready = 1'b1;
                        w_load_in  = 1'b1;
                        w_issue    = 1'b1;
                        w_op_next  = OP_OUT_TO_RAM;
                        w_advance  = 1'b1;
                    end
                end else if (w_instr_op == OP_RAM_TO_OUT) begin
                    w_issue      = 1'b1;
                    w_op_next    = OP_RAM_TO_OUT;
                    w_state_next = S_CAPT;
                end else if (w_instr_op == NOP_OP) begin
                    w_advance = 1'b1;
                end else begin
                    w_issue   = 1'b1;
                    w_op_next = w_instr_op;
                    w_advance = 1'b1;
                end
            end
            // Second RamToOut cycle keeps the read command up while the RAM data settles.
            S_CAPT: begin
                w_op_next        = OP_RAM_TO_OUT;
                w_capture        = 1'b1;
                w_out_valid_next = 1'b1;
                w_state_next     = S_WOUT;
            end
            S_WOUT: begin
                if (out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_advance        = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_retired != 16'hFFFF) begin
                w_retired_next = r_retired + 16'd1;
            end
            if (r_pc == AW'(PROG_DEPTH - 1)) begin
                w_state_next = S_DONE;
            end else begin
                w_pc_next    = r_pc + 1'b1;
                w_state_next = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_retired   <= '0;
            r_op        <= NOP_OP;
            r_ram_addr  <= '0;
            r_ram_cnt   <= '0;
            r_reg_sel   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_retired   <= w_retired_next;
            r_op        <= w_op_next;
            r_out_valid <= w_out_valid_next;
            if (w_issue) begin
                r_ram_addr <= r_instr[14:6];
                r_ram_cnt  <= r_instr[5:2];
                r_reg_sel  <= r_instr[1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ram_input[gi] <= '0;
                    r_out_data[gi]  <= '0;
                end else begin
                    if (w_load_in) begin
                        r_ram_input[gi] <= in_data[gi];
                    end
                    if (w_capture) begin
                        r_out_data[gi] <= ram_output[gi];
                    end
                end
            end
            assign ram_input[gi] = r_ram_input[gi];
            assign out_data[gi]  = r_out_data[gi];
        end
    endgenerate

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pc        = r_pc;
    assign retired   = r_retired;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign op        = r_op;
    assign ram_addr  = r_ram_addr;
    assign ram_cnt   = r_ram_cnt;
    assign reg_sel   = r_reg_sel;

endmodule
